// File: rtl/rename_free_list.sv
// rename_free_list: multi-port circular free list of physical register tags for rename
// Ports: clk/rst (sync, active-high); alloc_req -> alloc_gnt/alloc_tag (combinational, all-or-nothing,
// lane-compacted); free_valid/free_tag push retired tags at tail; free_count/empty/full occupancy;
// overflow_err sticky drop flag; ckpt_save/ckpt_restore head snapshot, active only with
// RENAME_FREE_LIST_CKPT_EN defined.
module rename_free_list #(
    parameter int PREG_WIDTH  = 6,
    parameter int NUM_PREGS   = 64,
    parameter int NUM_AREGS   = 32,
    parameter int ALLOC_PORTS = 2,
    parameter int FREE_PORTS  = 2,
    localparam int DEPTH      = NUM_PREGS - NUM_AREGS,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ALLOC_PORTS-1:0]            alloc_req,
    output logic                              alloc_gnt,
    output logic [ALLOC_PORTS*PREG_WIDTH-1:0] alloc_tag,
    input  logic [FREE_PORTS-1:0]             free_valid,
    input  logic [FREE_PORTS*PREG_WIDTH-1:0]  free_tag,
    output logic [CW-1:0]                     free_count,
    output logic                              empty,
    output logic                              full,
    output logic                              overflow_err,
    input  logic                              ckpt_save,
    input  logic                              ckpt_restore
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [PREG_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] head, tail, head_next, tail_next, restore_head;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] waddr [FREE_PORTS];
    logic [FREE_PORTS-1:0] wen;
    logic restore, ovf_now;
    int n_req, n_free, n_alloc, base, ckpt_add, a_off, f_off;
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % DEPTH);
    endfunction
`ifdef RENAME_FREE_LIST_CKPT_EN
    logic [PW-1:0] ckpt_head;
    logic [CW-1:0] asc;
    assign restore      = ckpt_restore;
    assign ckpt_add     = ckpt_restore ? int'(asc) : 0;
    assign restore_head = ckpt_head;
    always_ff @(posedge clk) begin
        if (rst) begin
            ckpt_head <= '0;
            asc       <= '0;
        end else if (ckpt_restore) begin
            asc <= '0;
        end else if (ckpt_save) begin
            ckpt_head <= head_next;
            asc       <= '0;
        end else begin
            asc <= asc + CW'(n_alloc);
        end
    end
`else
    logic unused_ckpt;
    assign unused_ckpt  = ckpt_save ^ ckpt_restore;
    assign restore      = 1'b0;
    assign ckpt_add     = 0;
    assign restore_head = head;
`endif
    always_comb begin
        n_req  = 0;
        n_free = 0;
        for (int i = 0; i < ALLOC_PORTS; i++) n_req += alloc_req[i] ? 1 : 0;
        for (int j = 0; j < FREE_PORTS; j++) n_free += free_valid[j] ? 1 : 0;
        alloc_gnt = n_req <= int'(count) && !restore;
        n_alloc   = alloc_gnt ? n_req : 0;
        alloc_tag = '0;
        a_off     = 0;
        // requesting lanes take consecutive entries from head in lane order
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            if (alloc_req[i]) begin
                if (alloc_gnt) alloc_tag[i*PREG_WIDTH +: PREG_WIDTH] = mem[wrap(int'(head) + a_off)];
                a_off++;
            end
        end
        base    = int'(count) - n_alloc + ckpt_add;
        ovf_now = base + n_free > DEPTH;
        // on overflow frees are dropped; clamp keeps a stale restore credit from exceeding capacity
        count_next = CW'(ovf_now ? (base > DEPTH ? DEPTH : base) : base + n_free);
        f_off = 0;
        for (int j = 0; j < FREE_PORTS; j++) begin
            waddr[j] = wrap(int'(tail) + f_off);
            wen[j]   = free_valid[j] && !ovf_now;
            f_off   += free_valid[j] ? 1 : 0;
        end
        head_next = restore ? restore_head : wrap(int'(head) + n_alloc);
        tail_next = wrap(int'(tail) + (ovf_now ? 0 : n_free));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= PREG_WIDTH'(NUM_AREGS + k);
            head         <= '0;
            tail         <= '0;
            count        <= CW'(DEPTH);
            full         <= 1'b1;
            empty        <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            for (int j = 0; j < FREE_PORTS; j++)
                if (wen[j]) mem[waddr[j]] <= free_tag[j*PREG_WIDTH +: PREG_WIDTH];
            head         <= head_next;
            tail         <= tail_next;
            count        <= count_next;
            full         <= count_next == CW'(DEPTH);
            empty        <= count_next == '0;
            overflow_err <= overflow_err | ovf_now;
        end
    end
    assign free_count = count;
endmodule

// File: tb/tb_rename_free_list.sv
// tb_rename_free_list: scoreboard bench for rename_free_list with directed vectors
module tb_rename_free_list;
    logic clk = 0, rst = 1;
    logic [1:0] alloc_req = 0, free_valid = 0;
    logic [11:0] free_tag = 0;
    logic ckpt_save = 0, ckpt_restore = 0;
    logic alloc_gnt, empty, full, overflow_err;
    logic [11:0] alloc_tag;
    logic [5:0] free_count;
    int vectors = 0, miscompares = 0;
    typedef struct { logic g; logic [11:0] t; int c; logic f, e, o; } exp_t;
    exp_t q[$];
    rename_free_list dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .free_valid(free_valid), .free_tag(free_tag), .free_count(free_count), .empty(empty),
        .full(full), .overflow_err(overflow_err), .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore)
    );
    always #5 clk = ~clk;
    function automatic void chk(string n, int a, int e);
        vectors++;
        if (a != e) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
        end
    endfunction
    function automatic logic [11:0] pk(int l1, int l0);
        return {6'(l1), 6'(l0)};
    endfunction
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            chk("gnt", int'(alloc_gnt), int'(x.g));
            chk("tag", int'(alloc_tag), int'(x.t));
            chk("count", int'(free_count), x.c);
            chk("full", int'(full), int'(x.f));
            chk("empty", int'(empty), int'(x.e));
            chk("overflow", int'(overflow_err), int'(x.o));
        end
    end
    task automatic step(input logic [1:0] req, input logic [1:0] fv, input int t1, input int t0,
                        input logic sv, input logic rs, input logic g, input logic [11:0] tg,
                        input int c, input logic f, input logic e, input logic o);
        exp_t x;
        alloc_req    = req;
        free_valid   = fv;
        free_tag     = pk(t1, t0);
        ckpt_save    = sv;
        ckpt_restore = rs;
        x = '{g, tg, c, f, e, o};
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1;
        alloc_req = 0; free_valid = 0; free_tag = 0; ckpt_save = 0; ckpt_restore = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask
    initial begin
        do_reset();
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 32, 1, 0, 0);
        step(2'b11, 0, 0, 0, 0, 0, 1, pk(33, 32), 32, 1, 0, 0);
        step(2'b11, 0, 0, 0, 0, 0, 1, pk(35, 34), 30, 0, 0, 0);
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 28, 0, 0, 0);
        do_reset();
        step(2'b10, 0, 0, 0, 0, 0, 1, pk(32, 0), 32, 1, 0, 0);
        step(2'b01, 0, 0, 0, 0, 0, 1, pk(0, 33), 31, 0, 0, 0);
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 30, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 15; i++)
            step(2'b11, 0, 0, 0, 0, 0, 1, pk(33 + 2 * i, 32 + 2 * i), 32 - 2 * i, i == 0, 0, 0);
        step(2'b01, 0, 0, 0, 0, 0, 1, pk(0, 62), 2, 0, 0, 0);
        step(2'b11, 2'b01, 0, 5, 0, 0, 0, pk(0, 0), 1, 0, 0, 0);
        step(2'b11, 0, 0, 0, 0, 0, 1, pk(5, 63), 2, 0, 0, 0);
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 0, 0, 1, 0);
        step(2'b01, 2'b11, 10, 9, 0, 0, 0, pk(0, 0), 0, 0, 1, 0);
        step(2'b11, 0, 0, 0, 0, 0, 1, pk(10, 9), 2, 0, 0, 0);
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 0, 0, 1, 0);
        do_reset();
        step(2'b00, 2'b11, 2, 1, 0, 0, 1, pk(0, 0), 32, 1, 0, 0);
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 32, 1, 0, 1);
        step(2'b11, 2'b01, 0, 3, 0, 0, 1, pk(33, 32), 32, 1, 0, 1);
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 31, 0, 0, 1);
        do_reset();
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 32, 1, 0, 0);
        do_reset();
`ifdef RENAME_FREE_LIST_CKPT_EN
        step(2'b00, 0, 0, 0, 1, 0, 1, pk(0, 0), 32, 1, 0, 0);
        step(2'b11, 0, 0, 0, 0, 0, 1, pk(33, 32), 32, 1, 0, 0);
        step(2'b01, 0, 0, 0, 0, 0, 1, pk(0, 34), 30, 0, 0, 0);
        step(2'b11, 2'b01, 0, 7, 0, 1, 0, pk(0, 0), 29, 0, 0, 0);
        step(2'b11, 0, 0, 0, 0, 0, 1, pk(33, 32), 32, 1, 0, 1);
`else
        step(2'b11, 0, 0, 0, 1, 1, 1, pk(33, 32), 32, 1, 0, 0);
        step(2'b00, 0, 0, 0, 0, 0, 1, pk(0, 0), 30, 0, 0, 0);
`endif
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
